div_arbiter: RTL and testbench

//  Shares one iterative divider (integer ALU_DIV and float FALU_DIV paths) among NUM_REQ execution lanes.
//  - Sits between the per-lane execute stages and the divider.
//  - Round-robin grant, operand capture, start/done sequencing, result routing back to the owning lane.
//  - Integer divide-by-zero is short-circuited; a watchdog bounds a hung divider.

---
 rtl/div_arbiter_if.sv | 34 +++
 rtl/div_arbiter.sv | 176 +++++++++++++++++
 tb/tb_div_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_arbiter_if.sv
// Lane/divider bundle for the shared divider arbiter.
// slave = arbiter side, master = lanes plus divider side.
interface div_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_float;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic                          resp_err;
    logic                          div_start;
    logic                          div_float;
    logic [DATA_WIDTH-1:0]         div_a;
    logic [DATA_WIDTH-1:0]         div_b;
    logic                          div_done;
    logic [DATA_WIDTH-1:0]         div_result;
    logic                          busy;

    modport slave (
        input  req_valid, req_float, req_a, req_b, div_done, div_result,
        output req_ready, resp_valid, resp_data, resp_err,
               div_start, div_float, div_a, div_b, busy
    );

    modport master (
        output req_valid, req_float, req_a, req_b, div_done, div_result,
        input  req_ready, resp_valid, resp_data, resp_err,
               div_start, div_float, div_a, div_b, busy
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin sharing of one iterative divider among NUM_REQ lanes; grant T -> start T+1, done D -> resp D+1.
// Lanes hold req_valid until their one-cycle req_ready; one op in flight, others wait in IDLE arbitration.
module div_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    div_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                state_q,      state_d;
    logic [IDX_W-1:0]      rr_ptr_q,     rr_ptr_d;
    logic [IDX_W-1:0]      gnt_idx_q,    gnt_idx_d;
    logic [WD_W-1:0]       wd_q,         wd_d;
    logic [DATA_WIDTH-1:0] div_a_q,      div_a_d;
    logic [DATA_WIDTH-1:0] div_b_q,      div_b_d;
    logic                  div_float_q,  div_float_d;
    logic                  div_start_q,  div_start_d;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q,  resp_data_d;
    logic                  resp_err_q,   resp_err_d;

    logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];
    logic                  any_req;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W:0]        cand;
    logic                  grant_now;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
            b_arr[i] = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First requesting lane at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        any_req  = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!any_req && bus.req_valid[cand[IDX_W-1:0]]) begin
                any_req  = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Gated by rst_n so a lane never sees its operands taken while the block is held in reset.
    assign grant_now = rst_n && (state_q == ST_IDLE) && any_req;

    always_comb begin
        bus.req_ready = '0;
        if (grant_now) begin
            bus.req_ready = NUM_REQ'(1) << pick_idx;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_idx_d    = gnt_idx_q;
        wd_d         = wd_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        div_float_d  = div_float_q;
        div_start_d  = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_idx_d   = pick_idx;
                    div_a_d     = a_arr[pick_idx];
                    div_b_d     = b_arr[pick_idx];
                    div_float_d = bus.req_float[pick_idx];
                    // Integer divide-by-zero never reaches the divider.
                    if (!bus.req_float[pick_idx] && (b_arr[pick_idx] == '0)) begin
                        resp_valid_d = NUM_REQ'(1) << pick_idx;
                        resp_data_d  = '1;
                        resp_err_d   = 1'b0;
                        state_d      = ST_RESP;
                    end else begin
                        div_start_d = 1'b1;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.div_done) begin
                    resp_valid_d = NUM_REQ'(1) << gnt_idx_q;
                    resp_data_d  = bus.div_result;
                    resp_err_d   = 1'b0;
                    state_d      = ST_RESP;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    resp_valid_d = NUM_REQ'(1) << gnt_idx_q;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_RESP: begin
                resp_valid_d = '0;
                resp_data_d  = '0;
                resp_err_d   = 1'b0;
                rr_ptr_d     = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            gnt_idx_q    <= '0;
            wd_q         <= '0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            div_float_q  <= 1'b0;
            div_start_q  <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_idx_q    <= gnt_idx_d;
            wd_q         <= wd_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            div_float_q  <= div_float_d;
            div_start_q  <= div_start_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.div_start  = div_start_q;
    assign bus.div_float  = div_float_q;
    assign bus.div_a      = div_a_q;
    assign bus.div_b      = div_b_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: a small divider model replies a set number of cycles after div_start.
module tb_div_arbiter;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n;

    div_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    div_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int resp_cnt = 0;
    int start_cnt = 0;

    logic          m_en = 1'b1;
    int            m_lat = 5;
    logic [DW-1:0] m_res = '0;
    int            m_cnt = 0;
    logic          m_done = 1'b0;
    logic          stray_done = 1'b0;

    assign bus.div_done   = m_done | stray_done;
    assign bus.div_result = m_res;

    // Divider model: done pulse m_lat cycles after the start cycle, plus pulse counters.
    always @(negedge clk) begin
        if (bus.div_start && m_en) begin
            m_cnt  = m_lat;
            m_done = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt  = m_cnt - 1;
            m_done = (m_cnt == 0);
        end else begin
            m_done = 1'b0;
        end
        if (|bus.resp_valid) resp_cnt++;
        if (bus.div_start) start_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int lane, input logic fl, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_valid = '0;
        bus.req_valid[lane] = 1'b1;
        bus.req_float[lane] = fl;
        bus.req_a[lane*DW +: DW] = a;
        bus.req_b[lane*DW +: DW] = b;
    endtask

    task automatic wait_resp(input int max, output int n);
        n = 0;
        while (n < max && bus.resp_valid == '0) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_ready(input int max, output logic [NR-1:0] rdy);
        int n;
        n = 0;
        while (n < max && bus.req_ready == '0) begin
            @(negedge clk); #1;
            n++;
        end
        rdy = bus.req_ready;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "bench stalled");
    end

    initial begin
        int n;
        int r0;
        int s0;
        logic [NR-1:0] rdy;
        int order [5];
        order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_float = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*DW +: DW] = 32'(10 + i);
            bus.req_b[i*DW +: DW] = 32'd3;
        end
        bus.req_valid = 4'b1111;
        m_en = 1'b1; m_lat = 2; m_res = 32'd5;

        // Reset state, with every lane already requesting.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_req_ready",  32'(bus.req_ready),  32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_div_start",  32'(bus.div_start),  32'd0);
        chk("rst_div_a",      bus.div_a,           32'd0);
        chk("rst_div_b",      bus.div_b,           32'd0);
        chk("rst_resp_data",  bus.resp_data,       32'd0);
        chk("rst_resp_err",   32'(bus.resp_err),   32'd0);

        // Fairness: all lanes held high, grants 0,1,2,3,0.
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_ready(20, rdy);
            chk("fair_grant", 32'(rdy), 32'(4'b0001 << order[k]));
            @(negedge clk); #1;
            wait_resp(20, n);
            chk("fair_resp", 32'(bus.resp_valid), 32'(rdy));
            @(negedge clk); #1;
        end
        bus.req_valid = '0;
        chk("fair_resp_cnt", 32'(resp_cnt), 32'd5);

        // Single int op, lane 2: 100/7, divider answers 14 five cycles after start.
        @(negedge clk); #1;
        m_lat = 5; m_res = 32'd14;
        s0 = start_cnt;
        set_req(2, 1'b0, 32'd100, 32'd7);
        #1;
        chk("t1_ready", 32'(bus.req_ready), 32'b0100);
        @(negedge clk); #1;
        bus.req_valid = '0;
        chk("t1_start",     32'(bus.div_start), 32'd1);
        chk("t1_div_a",     bus.div_a,          32'd100);
        chk("t1_div_b",     bus.div_b,          32'd7);
        chk("t1_div_float", 32'(bus.div_float), 32'd0);
        wait_resp(30, n);
        chk("t1_latency",    32'(n),              32'd6);
        chk("t1_resp_valid", 32'(bus.resp_valid), 32'b0100);
        chk("t1_resp_data",  bus.resp_data,       32'd14);
        chk("t1_resp_err",   32'(bus.resp_err),   32'd0);
        chk("t1_start_cnt",  32'(start_cnt - s0), 32'd1);
        @(negedge clk); #1;
        chk("t1_resp_clear", 32'(bus.resp_valid), 32'd0);
        chk("t1_data_clear", bus.resp_data,       32'd0);
        chk("t1_idle",       32'(bus.busy),       32'd0);

        // Int divide-by-zero, lane 1.
        s0 = start_cnt;
        set_req(1, 1'b0, 32'd5, 32'd0);
        #1;
        chk("t3_ready", 32'(bus.req_ready), 32'b0010);
        @(negedge clk); #1;
        bus.req_valid = '0;
        chk("t3_resp_valid", 32'(bus.resp_valid), 32'b0010);
        chk("t3_resp_data",  bus.resp_data,       32'hFFFF_FFFF);
        chk("t3_resp_err",   32'(bus.resp_err),   32'd0);
        @(negedge clk); #1;
        chk("t3_no_start",   32'(start_cnt - s0), 32'd0);
        chk("t3_idle",       32'(bus.busy),       32'd0);

        // Float op, lane 3: 6.0/2.0 = 3.0.
        m_lat = 3; m_res = 32'h4040_0000;
        set_req(3, 1'b1, 32'h40C0_0000, 32'h4000_0000);
        #1;
        chk("t4_ready", 32'(bus.req_ready), 32'b1000);
        @(negedge clk); #1;
        bus.req_valid = '0;
        chk("t4_start",     32'(bus.div_start), 32'd1);
        chk("t4_div_float", 32'(bus.div_float), 32'd1);
        chk("t4_div_a",     bus.div_a,          32'h40C0_0000);
        chk("t4_div_b",     bus.div_b,          32'h4000_0000);
        wait_resp(30, n);
        chk("t4_latency",    32'(n),              32'd4);
        chk("t4_resp_valid", 32'(bus.resp_valid), 32'b1000);
        chk("t4_resp_data",  bus.resp_data,       32'h4040_0000);
        @(negedge clk); #1;

        // Watchdog: divider never answers; RESP lands 64 cycles after entering WAIT.
        m_en = 1'b0; m_res = 32'hDEAD_BEEF;
        set_req(0, 1'b0, 32'd9, 32'd3);
        #1;
        chk("t5_ready", 32'(bus.req_ready), 32'b0001);
        @(negedge clk); #1;
        bus.req_valid = '0;
        wait_resp(200, n);
        chk("t5_latency",    32'(n),              32'd65);
        chk("t5_resp_valid", 32'(bus.resp_valid), 32'b0001);
        chk("t5_resp_err",   32'(bus.resp_err),   32'd1);
        chk("t5_resp_data",  bus.resp_data,       32'd0);
        @(negedge clk); #1;
        chk("t5_err_clear",  32'(bus.resp_err),   32'd0);
        r0 = resp_cnt;
        stray_done = 1'b1;
        @(negedge clk); #1;
        stray_done = 1'b0;
        chk("t5_stray_busy", 32'(bus.busy), 32'd0);
        @(negedge clk); #1;
        chk("t5_stray_resp", 32'(resp_cnt - r0), 32'd0);

        // Reset in the middle of WAIT, then the late done must be ignored.
        m_en = 1'b1; m_lat = 10; m_res = 32'd77;
        set_req(3, 1'b0, 32'd50, 32'd5);
        #1;
        chk("t6_ready", 32'(bus.req_ready), 32'b1000);
        @(negedge clk); #1;
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("t6_busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        r0 = resp_cnt;
        chk("t6_busy_post", 32'(bus.busy),       32'd0);
        chk("t6_resp_post", 32'(bus.resp_valid), 32'd0);
        chk("t6_div_a_clr", bus.div_a,           32'd0);
        repeat (12) @(negedge clk);
        #1;
        chk("t6_no_resp", 32'(resp_cnt - r0), 32'd0);
        chk("t6_idle",    32'(bus.busy),      32'd0);
        bus.req_valid = 4'b1111;
        #1;
        chk("t6_grant_lane0", 32'(bus.req_ready), 32'b0001);
        @(negedge clk); #1;
        bus.req_valid = '0;
        wait_resp(30, n);
        chk("t6_resp_valid", 32'(bus.resp_valid), 32'b0001);
        chk("t6_resp_data",  bus.resp_data,       32'd77);
        @(negedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
